// File: rtl/pwm_gen.sv
// pwm_gen: single-clock PWM generator with a programmable prescaler and a
// duty value that is sampled once per period.
//
// A prescaler issues a count-enable tick every sel_clk+1 clocks. On each
// tick the PWM_W-bit period counter advances and wraps after 2^PWM_W ticks.
// The output is at its active level while the counter is below the duty
// value latched at the previous period boundary. Because the duty is latched
// this way, periods stay glitch-free when sel_width changes mid-period.
//
// Parameters:
//   PWM_W       - width of sel_width and of the period counter (2^PWM_W ticks)
//   DIV_W       - width of sel_clk and of the prescaler counter
//   ACTIVE_HIGH - 1: the active level is 1; 0: the active level is 0
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   s_rst     - synchronous reset, active-high; drives the output inactive
//   sel_width - duty in ticks per period (0 .. 2^PWM_W-1)
//   sel_clk   - prescaler select; one tick every sel_clk+1 clocks
//   pwm       - registered PWM output
module pwm_gen #(
    parameter int PWM_W       = 4,
    parameter int DIV_W       = 4,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             s_rst,
    input  logic [PWM_W-1:0] sel_width,
    input  logic [DIV_W-1:0] sel_clk,
    output logic             pwm
);

    localparam logic ACT_LVL   = ACTIVE_HIGH;
    localparam logic INACT_LVL = ~ACTIVE_HIGH;

    logic [DIV_W-1:0] presc;
    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_q;
    logic             pwm_q;
    logic             tick;
    logic             period_end;

    // A >= compare rather than == avoids a full prescaler wrap when
    // sel_clk is lowered below the current prescaler count.
    assign tick       = (presc >= sel_clk);
    assign period_end = tick && (cnt == {PWM_W{1'b1}});

    always_ff @(posedge clk) begin
        if (s_rst) begin
            presc  <= '0;
            cnt    <= '0;
            duty_q <= '0;
            pwm_q  <= INACT_LVL;
        end else begin
            if (tick) begin
                presc <= '0;
                cnt   <= cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            // The new duty takes effect exactly when cnt wraps to 0.
            if (period_end) begin
                duty_q <= sel_width;
            end

            // The output is registered, so it lags cnt/duty_q by one clock.
            pwm_q <= (cnt < duty_q) ? ACT_LVL : INACT_LVL;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: self-checking bench for pwm_gen (PWM_W=4, DIV_W=4, active-high).
// A reference model follows the behaviour as total ticks elapsed and the duty
// assigned to each period number. On every clock edge it pushes the expected
// pwm value into a scoreboard queue. A separate monitor pops the queue on the
// falling edge and compares. Directed phases also count high clocks over
// whole periods and check them against fixed expected values.
module tb_pwm_gen;

    localparam int PWM_W = 4;
    localparam int DIV_W = 4;
    localparam int P     = 1 << PWM_W;

    logic             clk;
    logic             s_rst;
    logic [PWM_W-1:0] sel_width;
    logic [DIV_W-1:0] sel_clk;
    logic             pwm;

    int checks = 0;
    int fails  = 0;

    pwm_gen #(
        .PWM_W      (PWM_W),
        .DIV_W      (DIV_W),
        .ACTIVE_HIGH(1'b1)
    ) dut (
        .clk      (clk),
        .s_rst    (s_rst),
        .sel_width(sel_width),
        .sel_clk  (sel_clk),
        .pwm      (pwm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model + scoreboard producer ----------------
    logic   sb[$];
    bit     m_seen_rst = 1'b0;
    int     m_since_tick;          // clocks since the last tick
    int     m_ticks;               // ticks since reset
    int     period_duty[int];      // duty assigned to each period number
    bit     m_act;

    always @(posedge clk) begin
        if (s_rst) begin
            m_seen_rst   = 1'b1;
            m_since_tick = 0;
            m_ticks      = 0;
            period_duty.delete();
            period_duty[0] = 0;
            sb.push_back(1'b0);
        end else if (m_seen_rst) begin
            m_act = (m_ticks % P) < period_duty[m_ticks / P];
            sb.push_back(m_act ? 1'b1 : 1'b0);
            if (m_since_tick >= int'(sel_clk)) begin
                if ((m_ticks % P) == P - 1)
                    period_duty[m_ticks / P + 1] = int'(sel_width);
                m_ticks      = m_ticks + 1;
                m_since_tick = 0;
            end else begin
                m_since_tick = m_since_tick + 1;
            end
        end
    end

    // ---------------- monitor / scoreboard consumer ----------------
    logic exp_v;
    int   cyc = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sb.size() > 0) begin
            exp_v  = sb.pop_front();
            checks = checks + 1;
            if (pwm !== exp_v) begin
                fails = fails + 1;
                $display("FAIL sb_pwm cycle %0d: got %b expected %b", cyc, pwm, exp_v);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm === 1'b1) hi++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks = checks + 1;
        if (got != want) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    int  hi;
    bit  found;

    initial begin
        s_rst     = 1'b1;
        sel_width = '0;
        sel_clk   = '0;

        // Reset held for 2 clocks, then 20+ clocks with duty 0.
        @(posedge clk); #1;
        @(negedge clk);
        check_val("reset_pwm_low", int'(pwm === 1'b1), 0);
        @(posedge clk); #1;
        s_rst = 1'b0;
        count_high(24, hi);
        check_val("reset_idle_high_count", hi, 0);

        // Basic duty: width 4, sel_clk 0. After two periods it is settled.
        sel_width = 4'd4;
        step(40);
        count_high(16, hi);
        check_val("basic_w4_high", hi, 4);
        count_high(16, hi);
        check_val("basic_w4_high_rep", hi, 4);

        // Duty sweep 0..15, 160 clocks per step. Measure the last period.
        for (int w = 0; w < P; w++) begin
            sel_width = w[PWM_W-1:0];
            step(160 - 17);
            count_high(16, hi);
            check_val($sformatf("sweep_w%0d_high", w), hi, w);
        end

        // Prescaler: sel_clk=1, width 3 -> 6 high per 32; sel_clk=3 -> 12 per 64.
        sel_width = 4'd3;
        sel_clk   = 4'd1;
        step(100);
        count_high(32, hi);
        check_val("presc1_w3_high", hi, 6);
        sel_clk = 4'd3;
        step(200);
        count_high(64, hi);
        check_val("presc3_w3_high", hi, 12);

        // Mid-period width change (4 -> 10) early in a period.
        sel_clk   = 4'd0;
        sel_width = 4'd4;
        step(48);
        sel_width = 4'd10;
        step(40);
        count_high(16, hi);
        check_val("midchange_w10_high", hi, 10);

        // Drop sel_clk 7 -> 0 while the prescaler sits at 5.
        sel_clk = 4'd7;
        step(20);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            if (m_since_tick == 5) found = 1'b1;
        end
        check_val("presc5_reached", int'(found), 1);
        sel_clk = 4'd0;
        step(40);

        // Reset while the output is high.
        sel_width = 4'd12;
        step(40);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (pwm === 1'b1) found = 1'b1;
        end
        check_val("pwm_high_seen", int'(found), 1);
        @(posedge clk); #1;
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        count_high(15, hi);
        check_val("post_reset_first_period", hi, 0);
        step(40);
        count_high(16, hi);
        check_val("post_reset_resumed", hi, 12);

        // Randomised phase: inputs change at random times; the scoreboard checks.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) sel_width = PWM_W'($urandom);
            if ($urandom_range(0, 39) == 0) sel_clk = DIV_W'($urandom_range(0, 4));
            if ($urandom_range(0, 199) == 0) sel_clk = DIV_W'($urandom);
            s_rst = ($urandom_range(0, 499) == 0);
            step(1);
        end
        s_rst = 1'b0;
        step(4);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Single-clock PWM generator with programmable duty cycle and programmable prescaler.
- A prescaler produces a count-enable tick. A PWM_W-bit period counter advances on each tick.
- The output is active while the counter is below a duty value. The duty value is sampled from sel_width once per period.
- Drives LED, motor or fan loads from a register block that owns sel_width and sel_clk.

Parameters:
- PWM_W, 4, width of sel_width and of the period counter; period = 2^PWM_W ticks.
- DIV_W, 4, width of sel_clk and of the prescaler counter.
- ACTIVE_HIGH, 1, output polarity: 1 = active level is 1; 0 = active level is 0 (output inverted).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- s_rst, input, 1, synchronous reset, active-high.
- sel_width, input, PWM_W, duty in ticks per period (0 … 2^PWM_W-1).
- sel_clk, input, DIV_W, prescaler select; one tick every sel_clk+1 clocks.
- pwm, output, 1, registered PWM output.

Behaviour:
- Registers:
  - presc (DIV_W bits).
  - cnt (PWM_W bits).
  - duty_q (PWM_W bits).
  - pwm_q (1 bit), which drives pwm directly.
- Reset: while s_rst=1 at a clock edge:
  - presc=0, cnt=0, duty_q=0.
  - pwm_q = inactive level (0 when ACTIVE_HIGH=1, 1 when ACTIVE_HIGH=0).
  - Reset takes priority over every other update, including mid-period; the next period restarts cleanly from cnt=0.
- Tick: tick = (presc >= sel_clk), combinational.
  - Using >= means that if sel_clk is lowered below the current presc, a tick is issued on the next edge with no 2^DIV_W-cycle stall.
  - On tick: presc<=0. Otherwise presc<=presc+1.
  - sel_clk=0 gives a tick every clock.
- Period counter: on tick, cnt<=cnt+1, wrapping from 2^PWM_W-1 to 0. Without a tick, cnt holds.
- Duty sampling:
  - When tick=1 and cnt=2^PWM_W-1 (period end), duty_q<=sel_width.
  - Changes to sel_width mid-period are ignored until the next period boundary, so periods are glitch-free.
  - The first period after reset uses duty_q=0, so the output is inactive for the whole first period.
- Output:
  - Every clock (not in reset), pwm_q <= active level if (cnt < duty_q), else the inactive level.
  - This is one clock of latency from cnt/duty_q to pin.
  - Compare is unsigned, PWM_W bits.
- Duty range:
  - sel_width=0 gives a constant inactive level.
  - sel_width=W gives W ticks active, then 2^PWM_W-W ticks inactive, per period.
  - The maximum is (2^PWM_W-1)/2^PWM_W; 100% is not reachable by design.
- Period length = 2^PWM_W × (sel_clk+1) clocks when sel_clk is constant.
  - Active time = W × (sel_clk+1) clocks, contiguous, starting at each period boundary (offset by 1 clock of output latency).
- sel_clk changes take effect on the next tick decision; no sampling to period boundaries.
- No X propagation from the outputs after the first reset edge. Behaviour before the first reset is undefined.

Test Plan:
- Reset check: hold s_rst=1 for 2 clocks, then release with sel_clk=0, sel_width=0 -> pwm=0 throughout reset and for ≥20 clocks after; cnt wraps every 16 clocks.
- Basic duty: sel_clk=0, sel_width=4 applied at a period boundary -> from the following period, pwm high for exactly 4 clocks, low for 12, repeating with a 16-clock period.
- Duty sweep: sel_width stepped 0→15, one step every 160 clocks with sel_clk=0 -> each settled period shows a high time equal to the current sel_width (0…15 clocks) within a 16-clock period. Width 15 gives 15 high, 1 low. The new value applies only from the next period boundary.
- Prescaler: sel_clk=1, sel_width=3 -> period 32 clocks, high 6 clocks. With sel_clk=3 -> period 64 clocks, high 12 clocks.
- Mid-period changes:
  - Change sel_width 4→10 at cnt=2 -> the current period still shows 4 high; the next shows 10 high.
  - Drop sel_clk 7→0 while presc=5 -> a tick on the next edge, no stall.
- Reset mid-operation: assert s_rst while pwm is high -> pwm inactive on the next edge. After release, the first period is fully inactive, then duty resumes.
